// File: rtl/bus_control_sequencer_pkg.sv
// Shared definitions for the TTM4 bus control sequencer: widths, opcodes,
// FSM state encoding and the decoded-instruction record.
package bus_control_sequencer_pkg;

  localparam int TTM4_DATA_W  = 4;
  localparam int TTM4_INSTR_W = 4 + TTM4_DATA_W;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC_IM   = 4'b1110;
  localparam logic [3:0] OP_JMP_IM   = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_NEXT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_IN   = 2'd3
  } src_t;

  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_A    = 3'd1,
    DST_B    = 3'd2,
    DST_OUT  = 3'd3,
    DST_PC   = 3'd4
  } dst_t;

  typedef struct packed {
    src_t src;
    dst_t dst;
    logic use_imm;
    logic is_add;
    logic is_jmp;
    logic is_jnc;
  } decode_t;

  localparam decode_t DEC_NOP = '{src: SRC_NONE, dst: DST_NONE, use_imm: 1'b0,
                                  is_add: 1'b0, is_jmp: 1'b0, is_jnc: 1'b0};

endpackage

// File: rtl/bus_control_sequencer_instr_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode to bus source, store
// destination and the flags the sequencer needs for carry and jumps.
module bus_control_sequencer_instr_decode
  import bus_control_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  // Opcode table; unlisted opcodes decode to a NOP that still advances the PC.
  always_comb begin
    dec = DEC_NOP;
    case (opcode)
      OP_ADD_A_IM: begin dec.src = SRC_A;  dec.dst = DST_A; dec.use_imm = 1'b1; dec.is_add = 1'b1; end
      OP_MOV_A_B:  begin dec.src = SRC_B;  dec.dst = DST_A; end
      OP_IN_A:     begin dec.src = SRC_IN; dec.dst = DST_A; end
      OP_MOV_A_IM: begin dec.dst = DST_A;  dec.use_imm = 1'b1; end
      OP_MOV_B_A:  begin dec.src = SRC_A;  dec.dst = DST_B; end
      OP_ADD_B_IM: begin dec.src = SRC_B;  dec.dst = DST_B; dec.use_imm = 1'b1; dec.is_add = 1'b1; end
      OP_IN_B:     begin dec.src = SRC_IN; dec.dst = DST_B; end
      OP_MOV_B_IM: begin dec.dst = DST_B;  dec.use_imm = 1'b1; end
      OP_OUT_B:    begin dec.src = SRC_B;  dec.dst = DST_OUT; end
      OP_OUT_IM:   begin dec.dst = DST_OUT; dec.use_imm = 1'b1; end
      OP_JNC_IM:   begin dec.dst = DST_PC; dec.use_imm = 1'b1; dec.is_jnc = 1'b1; end
      OP_JMP_IM:   begin dec.dst = DST_PC; dec.use_imm = 1'b1; dec.is_jmp = 1'b1; end
      default:     dec = DEC_NOP;
    endcase
  end

endmodule

// File: rtl/bus_control_sequencer.sv
// TTM4 bus control sequencer: 4-cycle FETCH/DECODE/EXEC/NEXT machine with
// instruction register, carry flag and glitch-free registered bus strobes.
module bus_control_sequencer
  import bus_control_sequencer_pkg::*;
#(
  parameter int DATA_W  = TTM4_DATA_W,
  parameter int INSTR_W = TTM4_INSTR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RUN,
  input  logic               STEP,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               ALU_CO,
  output logic [DATA_W-1:0]  IMM,
  output logic               nA_OUT,
  output logic               nB_OUT,
  output logic               nIN_OUT,
  output logic               nA_ST,
  output logic               nB_ST,
  output logic               nOUT_ST,
  output logic               nPC_ST,
  output logic               PC_INC,
  output logic               CARRY,
  output logic               BUSY
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic               jump_taken;
  logic [INSTR_W-1:0] dec_word;
  logic               jump_now;
  decode_t            dec;

  // Outputs for DECODE are loaded on the FETCH edge, so decode the ROM word
  // directly there; afterwards the latched IR drives the decoder.
  always_comb begin
    if (state == ST_FETCH) begin
      dec_word = INSTR;
    end else begin
      dec_word = ir;
    end
    jump_now = dec.is_jmp | (dec.is_jnc & ~CARRY);
  end

  bus_control_sequencer_instr_decode u_decode (
    .opcode (dec_word[INSTR_W-1 -: 4]),
    .dec    (dec)
  );

  // Sequencer FSM with every output registered; reset aborts any pending store.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_FETCH;
      ir         <= '0;
      jump_taken <= 1'b0;
      CARRY      <= 1'b0;
      IMM        <= '0;
      nA_OUT     <= 1'b1;
      nB_OUT     <= 1'b1;
      nIN_OUT    <= 1'b1;
      nA_ST      <= 1'b1;
      nB_ST      <= 1'b1;
      nOUT_ST    <= 1'b1;
      nPC_ST     <= 1'b1;
      PC_INC     <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (RUN | STEP) begin
            state   <= ST_DECODE;
            ir      <= INSTR;
            BUSY    <= 1'b1;
            nA_OUT  <= ~(dec.src == SRC_A);
            nB_OUT  <= ~(dec.src == SRC_B);
            nIN_OUT <= ~(dec.src == SRC_IN);
            IMM     <= dec.use_imm ? INSTR[DATA_W-1:0] : {DATA_W{1'b0}};
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          state      <= ST_EXEC;
          nA_ST      <= ~(dec.dst == DST_A);
          nB_ST      <= ~(dec.dst == DST_B);
          nOUT_ST    <= ~(dec.dst == DST_OUT);
          nPC_ST     <= ~jump_now;
          jump_taken <= jump_now;
        end
        ST_EXEC: begin
          state   <= ST_NEXT;
          nA_OUT  <= 1'b1;
          nB_OUT  <= 1'b1;
          nIN_OUT <= 1'b1;
          nA_ST   <= 1'b1;
          nB_ST   <= 1'b1;
          nOUT_ST <= 1'b1;
          nPC_ST  <= 1'b1;
          IMM     <= '0;
          PC_INC  <= ~jump_taken;
          CARRY   <= dec.is_add & ALU_CO;
        end
        ST_NEXT: begin
          state      <= ST_FETCH;
          PC_INC     <= 1'b0;
          BUSY       <= 1'b0;
          jump_taken <= 1'b0;
        end
        default: begin
          state   <= ST_FETCH;
          nA_OUT  <= 1'b1;
          nB_OUT  <= 1'b1;
          nIN_OUT <= 1'b1;
          nA_ST   <= 1'b1;
          nB_ST   <= 1'b1;
          nOUT_ST <= 1'b1;
          nPC_ST  <= 1'b1;
          PC_INC  <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Self-checking bench: directed scenarios plus a random instruction stream,
// compared cycle by cycle against an instruction-level reference model.
module tb_bus_control_sequencer;

  logic       CLK = 1'b0;
  logic       RST, RUN, STEP, ALU_CO;
  logic [7:0] INSTR;
  logic [3:0] IMM;
  logic       nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_ST;
  logic       PC_INC, CARRY, BUSY;

  int   checks = 0;
  int   errors = 0;
  logic m_c    = 1'b0;

  bus_control_sequencer dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .INSTR(INSTR), .ALU_CO(ALU_CO),
    .IMM(IMM), .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIN_OUT(nIN_OUT),
    .nA_ST(nA_ST), .nB_ST(nB_ST), .nOUT_ST(nOUT_ST), .nPC_ST(nPC_ST),
    .PC_INC(PC_INC), .CARRY(CARRY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [13:0] obs_outs();
    return {nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_ST, PC_INC, BUSY, CARRY, IMM};
  endfunction

  // Expected outputs in phase ph (0 fetch, 1 decode, 2 exec, 3 next) of an
  // instruction, from the opcode table; cb is C before the instruction.
  function automatic logic [13:0] exp_outs(input int ph, input logic [7:0] ins,
                                           input logic cb, input logic co);
    int   src = 0;  // 0 none, 1 A, 2 B, 3 IN
    int   dst = 0;  // 0 none, 1 A, 2 B, 3 OUT, 4 PC
    bit   uimm = 0, add = 0, taken, act;
    logic [3:0] op = ins[7:4];
    logic [3:0] imm;
    case (op)
      4'h0: begin src = 1; dst = 1; uimm = 1; add = 1; end
      4'h1: begin src = 2; dst = 1; end
      4'h2: begin src = 3; dst = 1; end
      4'h3: begin dst = 1; uimm = 1; end
      4'h4: begin src = 1; dst = 2; end
      4'h5: begin src = 2; dst = 2; uimm = 1; add = 1; end
      4'h6: begin src = 3; dst = 2; end
      4'h7: begin dst = 2; uimm = 1; end
      4'h9: begin src = 2; dst = 3; end
      4'hB: begin dst = 3; uimm = 1; end
      4'hE: begin dst = 4; uimm = 1; end
      4'hF: begin dst = 4; uimm = 1; end
      default: begin src = 0; dst = 0; end
    endcase
    taken = (dst == 4) && (op == 4'hF || cb == 1'b0);
    act   = (ph == 1) || (ph == 2);
    imm   = (act && uimm) ? ins[3:0] : 4'h0;
    return {!(act && src == 1), !(act && src == 2), !(act && src == 3),
            !(ph == 2 && dst == 1), !(ph == 2 && dst == 2), !(ph == 2 && dst == 3),
            !(ph == 2 && taken), (ph == 3 && !taken), (ph != 0),
            (ph == 3) ? (add ? co : 1'b0) : cb, imm};
  endfunction

  function automatic bit is_add(input logic [7:0] ins);
    return (ins[7:4] == 4'h0) || (ins[7:4] == 4'h5);
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge of a FETCH cycle; returns at the next FETCH.
  task automatic run_instr(input logic [7:0] ins, input logic co,
                           input bit by_step, input logic run_after);
    INSTR  = ins;
    ALU_CO = co;
    if (by_step) STEP = 1'b1;
    check($sformatf("fetch ins=%h", ins), obs_outs(), exp_outs(0, ins, m_c, co));
    for (int p = 1; p < 4; p++) begin
      @(negedge CLK);
      if (p == 1) begin
        if (by_step) STEP = 1'b0;
        RUN   = run_after;
        INSTR = 8'($urandom_range(0, 255));
      end
      check($sformatf("phase%0d ins=%h", p, ins), obs_outs(), exp_outs(p, ins, m_c, co));
    end
    m_c = is_add(ins) ? co : 1'b0;
    @(negedge CLK);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle", obs_outs(), exp_outs(0, 8'h00, m_c, 1'b0));
    end
  endtask

  // Start an instruction, raise RST after phase 'upto', expect a clean abort.
  task automatic rst_during(input logic [7:0] ins, input logic co, input int upto);
    INSTR  = ins;
    ALU_CO = co;
    check("rst fetch", obs_outs(), exp_outs(0, ins, m_c, co));
    for (int p = 1; p <= upto; p++) begin
      @(negedge CLK);
      check($sformatf("rst phase%0d", p), obs_outs(), exp_outs(p, ins, m_c, co));
    end
    RST = 1'b1;
    @(negedge CLK);
    m_c = 1'b0;
    check($sformatf("rst abort after %0d", upto), obs_outs(), exp_outs(0, ins, 1'b0, co));
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; RUN = 1'b0; STEP = 1'b0; ALU_CO = 1'b0; INSTR = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset", obs_outs(), exp_outs(0, 8'h00, 1'b0, 1'b0));
    RST = 1'b0;
    RUN = 1'b1;

    run_instr(8'h03, 1'b0, 0, 1'b1);   // ADD A,3 no carry
    run_instr(8'h52, 1'b1, 0, 1'b1);   // ADD B,2 sets C
    run_instr(8'hE5, 1'b0, 0, 1'b1);   // JNC not taken, clears C
    run_instr(8'h37, 1'b0, 0, 1'b1);   // MOV A,7
    run_instr(8'hEA, 1'b0, 0, 1'b1);   // JNC taken
    run_instr(8'h52, 1'b1, 0, 1'b1);
    run_instr(8'hF9, 1'b0, 0, 1'b1);   // JMP with C=1
    run_instr(8'h8C, 1'b1, 0, 1'b1);   // NOP

    run_instr(8'h52, 1'b1, 0, 1'b1);
    rst_during(8'h03, 1'b1, 1);        // reset before the store cycle
    run_instr(8'h52, 1'b1, 0, 1'b1);
    rst_during(8'h52, 1'b1, 2);        // reset in EXEC drops carry update
    run_instr(8'h21, 1'b0, 0, 1'b1);

    RUN = 1'b0;
    idle_check(2);
    for (int k = 0; k < 3; k++) begin
      run_instr(8'h90, 1'($urandom_range(0, 1)), 1, 1'b0);
      idle_check(3);
    end

    STEP = 1'b1;                       // held STEP: one instruction per fetch
    run_instr(8'h64, 1'b0, 0, 1'b0);
    run_instr(8'h9F, 1'b0, 0, 1'b0);
    STEP = 1'b0;
    idle_check(2);

    RUN = 1'b1;
    run_instr(8'h01, 1'b0, 0, 1'b0);   // RUN drops mid-instruction
    idle_check(2);
    RUN = 1'b1;

    for (int k = 0; k < 1000; k++) begin
      run_instr(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
